adder_operand_loader: RTL and testbench
=======================================

// Module: adder_operand_loader
// PURPOSE
//  Upstream sequencer for the 8x4-bit register-file adder stage.
//  - Accepts a 16-bit operand pair on a start pulse.
//  - Writes the pair into the register file one nibble per cycle.
//  - Captures the 17-bit sum, then optionally reads every nibble back and flags mismatches.
//  - Sits between the control host and the register-file adder; drives its RW/data/addr pins.
// PARAMETERS
//  VERIFY_EN  1  1: run the read-back VERIFY phase; 0: skip it (SETTLE goes straight to DONE)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high reset
//  start       in   1   begin a load; sampled only in IDLE
//  op_a        in   16  operand A; nibble k goes to register address k (k=0..3)
//  op_b        in   16  operand B; nibble k goes to register address 4+k
//  RW          out  1   to adder stage: 0=write, 1=read/hold
//  data        out  4   to adder stage: write nibble
//  addr        out  3   to adder stage: register address
//  read_value  in   4   from adder stage: nibble at addr (combinational)
//  add_sout    in   16  from adder stage: sum of regs 0-3 and regs 4-7
//  add_cout    in   1   from adder stage: carry out
//  busy        out  1   high from the cycle after start until done
//  done        out  1   one-cycle pulse when the result is valid
//  sum         out  17  {add_cout, add_sout} captured in SETTLE; held until next capture
//  err         out  1   read-back mismatch seen in the last run; updated with done
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, RW=1, data=0, addr=0, busy=0, done=0, sum=0, err=0.
//    It does not clear the adder's register file, which has its own reset.
//  - IDLE: RW=1, addr=0. On start=1, latch op_a/op_b into op_q and go to WRITE with cnt=0.
//    Changes on op_a/op_b after the start cycle are ignored.
//  - WRITE: RW=0, addr=cnt, data=op_q nibble cnt, where cnt 0-3 selects A[4k+3:4k]
//    and cnt 4-7 selects B. cnt increments each cycle. After cnt=7, go to SETTLE.
//    Total: 8 cycles.
//  - SETTLE: RW=1. The register file now holds all 8 nibbles.
//    At the clock edge ending SETTLE: sum <= {add_cout, add_sout}.
//    Next state: VERIFY with cnt=0 if VERIFY_EN=1, else DONE.
//  - VERIFY: RW=1, addr=cnt. Each cycle compare read_value with expected nibble cnt;
//    any mismatch sets err_acc. After cnt=7, go to DONE. Total: 8 cycles.
//  - DONE: done=1 for exactly 1 cycle, err <= err_acc, busy=0 next cycle, return to IDLE.
//    err_acc is cleared on entry to WRITE.
//  - Latency from the start cycle t: done at t+18 (VERIFY_EN=1) or t+10 (VERIFY_EN=0).
//  - busy is high on t+1 through the DONE cycle.
//  - start while busy: ignored, no queuing. start in the DONE cycle: ignored.
//  - start held high: a new run begins on each IDLE visit, i.e. back-to-back runs
//    separated by one IDLE cycle.
//  - Reset mid-run: abort immediately to IDLE, RW=1 on the next cycle. Partial writes may
//    remain in the register file; sum and err go to 0.
//  - Arithmetic: none internally; sum = 17-bit concatenation, no truncation.
//  - RW is never 0 outside WRITE; no write is ever issued during reset.
// STRUCTURE
//  - Shared package adder_pkg:
//    - state localparams IDLE, WRITE, SETTLE, VERIFY, DONE (3-bit);
//    - NIBBLES=8, NIB_W=4, ADDR_W=3.
//  - One sub-module: operand_nibble_mux (32-bit op_q, 3-bit sel -> 4-bit nibble).
//    It is shared by the WRITE data path and the VERIFY compare.
//  - Top: FSM, 3-bit cnt, op_q register, sum/err registers.
// TESTING  (bench pairs the block with the register-file adder)
//  - Reset, then A=16'h1234, B=16'h4321 -> writes addr0..7 = 4,3,2,1,1,2,3,4;
//    done at t+18; sum=17'h05555; err=0.
//  - A=16'hFFFF, B=16'h0001 -> sum=17'h10000 (carry set); err=0.
//  - start pulsed again at t+5 during a run -> ignored; exactly one done; sum unchanged.
//  - Bench forces read_value=4'h0 at VERIFY cnt=2, with A=16'h0F00 -> err=1 with done;
//    sum still 17'h00F00 when B=0.
//  - reset asserted at WRITE cnt=3 -> next cycle RW=1, busy=0, sum=0;
//    a following run with A=B=16'h8000 gives sum=17'h10000.
//  - VERIFY_EN=0, A=16'h00FF, B=16'h0F01 -> done at t+10, sum=17'h01000;
//    RW never 0 after t+8.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and FSM states for the register-file adder operand loader
package adder_pkg;
  localparam int NIBBLES = 8;
  localparam int NIB_W = 4;
  localparam int ADDR_W = 3;
  typedef enum logic [2:0] {IDLE, WRITE, SETTLE, VERIFY, DONE} state_t;
endpackage

// File: rtl/operand_nibble_mux.sv
// operand_nibble_mux: selects one nibble of the latched operand pair
module operand_nibble_mux
  import adder_pkg::*;
(
  input  logic [NIBBLES*NIB_W-1:0] op_i,
  input  logic [ADDR_W-1:0]        sel_i,
  output logic [NIB_W-1:0]         nib_o
);
  assign nib_o = op_i[sel_i*NIB_W +: NIB_W];
endmodule

// File: rtl/adder_operand_loader.sv
// adder_operand_loader: writes an operand pair nibble-wise into the adder register file, captures the sum, optionally verifies
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       op_a,
  input  logic [15:0]       op_b,
  output logic              RW,
  output logic [NIB_W-1:0]  data,
  output logic [ADDR_W-1:0] addr,
  input  logic [NIB_W-1:0]  read_value,
  input  logic [15:0]       add_sout,
  input  logic              add_cout,
  output logic              busy,
  output logic              done,
  output logic [16:0]       sum,
  output logic              err
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NIBBLES*NIB_W-1:0] op_q, op_d;
  logic [16:0] sum_q, sum_d;
  logic err_q, err_d, err_acc_q, err_acc_d;
  logic [NIB_W-1:0] nib;
  operand_nibble_mux u_mux (.op_i(op_q), .sel_i(cnt_q), .nib_o(nib));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    sum_d = sum_q;
    err_d = err_q;
    err_acc_d = err_acc_q;
    case (state_q)
      IDLE: if (start) begin
        op_d = {op_b, op_a};
        cnt_d = '0;
        err_acc_d = 1'b0;
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? SETTLE : WRITE;
      end
      SETTLE: begin
        sum_d = {add_cout, add_sout};
        cnt_d = '0;
        state_d = VERIFY_EN ? VERIFY : DONE;
        err_d = VERIFY_EN ? err_q : err_acc_q;
      end
      VERIFY: begin
        cnt_d = cnt_q + 3'd1;
        err_acc_d = err_acc_q | (read_value != nib);
        state_d = (cnt_q == 3'd7) ? DONE : VERIFY;
        err_d = (cnt_q == 3'd7) ? err_acc_d : err_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
      err_acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      sum_q <= sum_d;
      err_q <= err_d;
      err_acc_q <= err_acc_d;
    end
  end
  // reset also masks RW so an aborted WRITE cycle never lands in the register file
  assign RW = reset | (state_q != WRITE);
  assign addr = (state_q == WRITE || state_q == VERIFY) ? cnt_q : '0;
  assign data = (state_q == WRITE) ? nib : '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sum = sum_q;
  assign err = err_q;
endmodule

// File: tb/tb_adder_operand_loader.sv
// tb_adder_operand_loader: pairs both VERIFY_EN variants with a behavioural register-file adder
module tb_adder_operand_loader;
  logic clk = 1'b0;
  logic reset, start0, start1;
  logic [15:0] op_a, op_b;
  logic rw0, rw1, cout0, cout1, busy0, busy1, done0, done1, err0, err1;
  logic [3:0] data0, data1, rv0, rv1;
  logic [2:0] addr0, addr1;
  logic [15:0] sout0, sout1;
  logic [16:0] sum0, sum1;
  logic [3:0] rf0 [8];
  logic [3:0] rf1 [8];
  bit inject, late_wr;
  int checks = 0, errors = 0, dc0 = 0;
  logic [6:0] wlog0 [$];
  logic [6:0] wlog1 [$];
  typedef struct { logic [15:0] a, b; bit inj; logic [16:0] es; bit ee; } vec_t;
  vec_t tv [11];
  always #5 clk = ~clk;
  adder_operand_loader #(.VERIFY_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b), .RW(rw0), .data(data0),
    .addr(addr0), .read_value(rv0), .add_sout(sout0), .add_cout(cout0), .busy(busy0), .done(done0),
    .sum(sum0), .err(err0));
  adder_operand_loader #(.VERIFY_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a), .op_b(op_b), .RW(rw1), .data(data1),
    .addr(addr1), .read_value(rv1), .add_sout(sout1), .add_cout(cout1), .busy(busy1), .done(done1),
    .sum(sum1), .err(err1));
  always @(posedge clk) begin
    if (!rw0) begin rf0[addr0] <= data0; wlog0.push_back({addr0, data0}); end
    if (!rw1) begin rf1[addr1] <= data1; wlog1.push_back({addr1, data1}); end
  end
  always @(negedge clk) if (done0) dc0++;
  always_comb begin
    {cout0, sout0} = {1'b0, rf0[3], rf0[2], rf0[1], rf0[0]} + {1'b0, rf0[7], rf0[6], rf0[5], rf0[4]};
    {cout1, sout1} = {1'b0, rf1[3], rf1[2], rf1[1], rf1[0]} + {1'b0, rf1[7], rf1[6], rf1[5], rf1[4]};
    rv0 = (inject && busy0 && rw0 && addr0 == 3'd2) ? 4'h0 : rf0[addr0];
    rv1 = rf1[addr1];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit inj, input bit which,
                     input int restart_at, output int lat);
    @(negedge clk);
    wlog0.delete(); wlog1.delete();
    op_a = a; op_b = b; inject = inj; late_wr = 0;
    if (which) start1 = 1; else start0 = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start0 = 0; start1 = 0;
      if (lat == 1) begin op_a = 16'($urandom); op_b = 16'($urandom); end
      if (lat == restart_at) begin if (which) start1 = 1; else start0 = 1; end
      if (lat > 8 && !(which ? rw1 : rw0)) late_wr = 1;
    end while (!(which ? done1 : done0) && lat < 40);
  endtask
  task automatic check_writes(input string tag, input logic [15:0] a, input logic [15:0] b, input bit which);
    logic [31:0] ops;
    ops = {b, a};
    check({tag, " wr_count"}, which ? wlog1.size() : wlog0.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < (which ? wlog1.size() : wlog0.size()))
        check($sformatf("%s wr%0d", tag, k), which ? wlog1[k] : wlog0[k], {k[2:0], ops[4*k +: 4]});
    check({tag, " late_write"}, late_wr, 0);
  endtask
  initial begin
    int lat, d_before;
    logic [15:0] ra, rb;
    for (int k = 0; k < 8; k++) begin rf0[k] = 0; rf1[k] = 0; end
    reset = 1; start0 = 0; start1 = 0; op_a = 0; op_b = 0; inject = 0;
    repeat (3) @(negedge clk);
    check("rst RW", rw0, 1); check("rst data", data0, 0); check("rst addr", addr0, 0);
    check("rst busy", busy0, 0); check("rst done", done0, 0); check("rst sum", sum0, 0);
    check("rst err", err0, 0);
    reset = 0;
    tv[0] = '{16'h1234, 16'h4321, 0, 17'h05555, 0};
    tv[1] = '{16'hFFFF, 16'h0001, 0, 17'h10000, 0};
    tv[2] = '{16'h0F00, 16'h0000, 1, 17'h00F00, 1};
    tv[3] = '{16'h0000, 16'h0000, 0, 17'h00000, 0};
    tv[4] = '{16'hFFFF, 16'hFFFF, 0, 17'h1FFFE, 0};
    for (int i = 5; i < 11; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      tv[i] = '{ra, rb, 1'($urandom), {1'b0, ra} + {1'b0, rb}, 0};
      tv[i].ee = tv[i].inj && (ra[11:8] != 4'h0);
    end
    for (int i = 0; i < 11; i++) begin
      run(tv[i].a, tv[i].b, tv[i].inj, 0, 0, lat);
      check($sformatf("v%0d latency", i), lat, 18);
      check($sformatf("v%0d sum", i), sum0, tv[i].es);
      check($sformatf("v%0d err", i), err0, tv[i].ee);
      check_writes($sformatf("v%0d", i), tv[i].a, tv[i].b, 0);
    end
    run(16'h00FF, 16'h0F01, 0, 1, 0, lat);
    check("nv latency", lat, 10); check("nv sum", sum1, 17'h01000); check("nv err", err1, 0);
    check_writes("nv", 16'h00FF, 16'h0F01, 1);
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run(ra, rb, 0, 1, 0, lat);
      check($sformatf("nr%0d latency", i), lat, 10);
      check($sformatf("nr%0d sum", i), sum1, {1'b0, ra} + {1'b0, rb});
      check_writes($sformatf("nr%0d", i), ra, rb, 1);
    end
    d_before = dc0;
    run(16'h2222, 16'h1111, 0, 0, 5, lat);
    check("restart latency", lat, 18);
    repeat (25) @(negedge clk);
    check("restart one done", dc0 - d_before, 1);
    check("restart sum held", sum0, 17'h03333);
    check("restart idle", busy0, 0);
    @(negedge clk);
    op_a = 16'h1357; op_b = 16'h2468; start0 = 1; lat = 0;
    do begin @(negedge clk); lat++; end while (!done0 && lat < 40);
    check("held first latency", lat, 18);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done0 && lat < 40);
    start0 = 0;
    check("held second latency", lat, 19);
    check("held sum", sum0, 17'h037BF);
    repeat (3) @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; start0 = 1;
    repeat (4) begin @(negedge clk); start0 = 0; end
    check("abort addr", addr0, 3);
    reset = 1;
    #1 check("abort RW during reset", rw0, 1);
    @(negedge clk);
    check("abort RW", rw0, 1); check("abort busy", busy0, 0);
    check("abort sum", sum0, 0); check("abort err", err0, 0);
    reset = 0;
    run(16'h8000, 16'h8000, 0, 0, 0, lat);
    check("post latency", lat, 18); check("post sum", sum0, 17'h10000); check("post err", err0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
